// File: rtl/keypoint_fifo_pkg.sv
// -----------------------------------------------------------------------------
// keypoint_fifo_pkg
// Purpose : shared field widths and the FIFO entry packing used by the keypoint
//           buffer and by the descriptor stage downstream of it.
// Contents: COORD_W / ORIENT_W / SCORE_W, ENTRY_W (39 bits),
//           kp_entry_t = {eof, x, y, orientation, score},
//           frame_state_t for the frame controller,
//           makeEofEntry() helper that builds the all-zero EOF token.
// -----------------------------------------------------------------------------
package keypoint_fifo_pkg;

  localparam int COORD_W  = 10;
  localparam int ORIENT_W = 10;
  localparam int SCORE_W  = 8;
  localparam int ENTRY_W  = 1 + 2 * COORD_W + ORIENT_W + SCORE_W;

  // Packing order is shared with the descriptor stage, so keep eof as the MSB.
  typedef struct packed {
    logic                eof;
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [ORIENT_W-1:0] orientation;
    logic [SCORE_W-1:0]  score;
  } kp_entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_t;

  // An EOF token carries no keypoint data: every field is zero.
  function automatic kp_entry_t makeEofEntry();
    kp_entry_t e;
    e     = '0;
    e.eof = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/keypoint_fifo_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : single-clock show-ahead FIFO with registered storage.
// Ports   : i_clk, i_rst_n (async, active low)
//           i_wrEn / i_wrData   : push request and data (ignored when full)
//           i_rdEn              : pop request (ignored when empty)
//           o_rdData            : head entry, valid whenever o_empty is low
//           o_full / o_empty    : occupancy flags for the current cycle
// Pointers carry one extra MSB so full and empty can be told apart when the
// index bits are equal.
// -----------------------------------------------------------------------------
module sync_fifo
  import keypoint_fifo_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wrEn,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic             i_rdEn,
  output logic [WIDTH-1:0] o_rdData,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_empty = (r_wrPtr == r_rdPtr);

  // Flags are judged before the edge, so a push into a full FIFO is refused
  // even if a pop frees a slot on the same edge.
  assign w_push = i_wrEn && !o_full;
  assign w_pop  = i_rdEn && !o_empty;

  // Pointer registers: advance on accepted push/pop and wrap through the MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Storage array: no reset needed because the empty flag masks stale data.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
  end

  assign o_rdData = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/keypoint_fifo.sv
// -----------------------------------------------------------------------------
// keypoint_fifo
// Purpose : buffers FAST keypoints for the descriptor stage, caps the number
//           of keypoints per frame and closes every frame with an EOF token.
// Ports   : i_clk, i_rst_n (async, active low)
//           i_coordinate_X/Y, i_orientation, i_score, i_flag : keypoint input
//           i_start / i_end : one-cycle frame boundary pulses
//           o_kp_valid, i_kp_ready : output handshake (pop on valid && ready)
//           o_kp_X/Y/orientation/score, o_kp_eof : head entry (zero if empty)
//           o_kp_count   : keypoints accepted in the current frame
//           o_drop_count : keypoints dropped in the current frame (saturating)
//           o_overflow   : sticky drop indicator, cleared by i_start
// -----------------------------------------------------------------------------
module keypoint_fifo
  import keypoint_fifo_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int MAX_KP = 500
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [COORD_W-1:0]  i_coordinate_X,
  input  logic [COORD_W-1:0]  i_coordinate_Y,
  input  logic [ORIENT_W-1:0] i_orientation,
  input  logic [SCORE_W-1:0]  i_score,
  input  logic                i_flag,
  input  logic                i_start,
  input  logic                i_end,
  output logic                o_kp_valid,
  input  logic                i_kp_ready,
  output logic [COORD_W-1:0]  o_kp_X,
  output logic [COORD_W-1:0]  o_kp_Y,
  output logic [ORIENT_W-1:0] o_kp_orientation,
  output logic [SCORE_W-1:0]  o_kp_score,
  output logic                o_kp_eof,
  output logic [9:0]          o_kp_count,
  output logic [15:0]         o_drop_count,
  output logic                o_overflow
);

  frame_state_t r_state;
  frame_state_t w_nextState;
  logic         w_eofReq;
  logic         r_eofPend;
  logic [9:0]   r_kpCount;
  logic [15:0]  r_dropCount;
  logic         r_overflow;

  logic         w_full;
  logic         w_empty;
  logic         w_flagOk;
  logic         w_eofWrite;
  logic         w_kpWrite;
  logic         w_kpDrop;
  logic         w_pop;
  kp_entry_t    w_wrEntry;
  kp_entry_t    w_head;

  // Frame state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  // Frame controller: a restart without i_end still closes the old frame,
  // and i_start wins over a coincident i_end so the new frame is not lost.
  always_comb begin
    w_nextState = r_state;
    w_eofReq    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_nextState = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (i_start) begin
          w_eofReq = 1'b1;
        end else if (i_end) begin
          w_nextState = ST_IDLE;
          w_eofReq    = 1'b1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Write arbitration: the pending EOF owns the single write slot, then a
  // keypoint may use it if there is room and the per-frame cap is not hit.
  assign w_flagOk   = (r_state == ST_ACTIVE) && i_flag && !i_start;
  assign w_eofWrite = r_eofPend && !w_full;
  assign w_kpWrite  = w_flagOk && !w_eofWrite && !w_full &&
                      (r_kpCount != 10'(MAX_KP));
  assign w_kpDrop   = w_flagOk && !w_kpWrite;
  assign w_pop      = !w_empty && i_kp_ready;

  always_comb begin
    w_wrEntry             = makeEofEntry();
    if (!w_eofWrite) begin
      w_wrEntry.eof         = 1'b0;
      w_wrEntry.x           = i_coordinate_X;
      w_wrEntry.y           = i_coordinate_Y;
      w_wrEntry.orientation = i_orientation;
      w_wrEntry.score       = i_score;
    end
  end

  // EOF pending flag: a new request on the edge where the old token is being
  // written must survive, otherwise the new frame would lose its token; a
  // request while still pending simply merges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_eofPend <= 1'b0;
    else if (w_eofReq) r_eofPend <= 1'b1;
    else if (w_eofWrite) r_eofPend <= 1'b0;
  end

  // Per-frame statistics, cleared on every i_start (the flag is ignored in
  // that cycle, so clearing never races with a write or drop).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kpCount   <= '0;
      r_dropCount <= '0;
      r_overflow  <= 1'b0;
    end else if (i_start) begin
      r_kpCount   <= '0;
      r_dropCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_kpWrite) r_kpCount <= r_kpCount + 10'd1;
      if (w_kpDrop) begin
        r_overflow <= 1'b1;
        if (r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 16'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wrEn   (w_eofWrite || w_kpWrite),
    .i_wrData (w_wrEntry),
    .i_rdEn   (w_pop),
    .o_rdData (w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Head fields are forced to zero when empty so no uninitialised storage
  // ever reaches the outputs (including straight after reset).
  assign o_kp_valid       = !w_empty;
  assign o_kp_eof         = !w_empty && w_head.eof;
  assign o_kp_X           = w_empty ? '0 : w_head.x;
  assign o_kp_Y           = w_empty ? '0 : w_head.y;
  assign o_kp_orientation = w_empty ? '0 : w_head.orientation;
  assign o_kp_score       = w_empty ? '0 : w_head.score;
  assign o_kp_count       = r_kpCount;
  assign o_drop_count     = r_dropCount;
  assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_keypoint_fifo.sv
// -----------------------------------------------------------------------------
// tb_keypoint_fifo
// Purpose : self-checking bench for keypoint_fifo. A queue-based frame model
//           predicts the head entry and counters every cycle; directed frames
//           pin the model with hand-computed values, then random frames run.
// -----------------------------------------------------------------------------
module tb_keypoint_fifo;
  import keypoint_fifo_pkg::*;

  localparam int DEPTH  = 64;
  localparam int MAX_KP = 100;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic [COORD_W-1:0]  i_coordinate_X = '0;
  logic [COORD_W-1:0]  i_coordinate_Y = '0;
  logic [ORIENT_W-1:0] i_orientation = '0;
  logic [SCORE_W-1:0]  i_score = '0;
  logic                i_flag = 1'b0;
  logic                i_start = 1'b0;
  logic                i_end = 1'b0;
  logic                i_kp_ready = 1'b0;
  logic                o_kp_valid;
  logic [COORD_W-1:0]  o_kp_X;
  logic [COORD_W-1:0]  o_kp_Y;
  logic [ORIENT_W-1:0] o_kp_orientation;
  logic [SCORE_W-1:0]  o_kp_score;
  logic                o_kp_eof;
  logic [9:0]          o_kp_count;
  logic [15:0]         o_drop_count;
  logic                o_overflow;

  int testsRun = 0;
  int testsFailed = 0;

  keypoint_fifo #(
    .DEPTH  (DEPTH),
    .MAX_KP (MAX_KP)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_coordinate_X   (i_coordinate_X),
    .i_coordinate_Y   (i_coordinate_Y),
    .i_orientation    (i_orientation),
    .i_score          (i_score),
    .i_flag           (i_flag),
    .i_start          (i_start),
    .i_end            (i_end),
    .o_kp_valid       (o_kp_valid),
    .i_kp_ready       (i_kp_ready),
    .o_kp_X           (o_kp_X),
    .o_kp_Y           (o_kp_Y),
    .o_kp_orientation (o_kp_orientation),
    .o_kp_score       (o_kp_score),
    .o_kp_eof         (o_kp_eof),
    .o_kp_count       (o_kp_count),
    .o_drop_count     (o_drop_count),
    .o_overflow       (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // One comparison: counts it, and reports it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: the FIFO is a queue of entries, the frame is a flag, and the
  // counters follow the accept/drop rules directly.
  kp_entry_t mQ[$];
  bit        mActive;
  bit        mEofPend;
  bit        mOverflow;
  int        mKpCount;
  int        mDropCount;

  always @(posedge i_clk or negedge i_rst_n) begin
    bit full, flagOk, eofSlot, pushed, req;
    kp_entry_t e;
    if (!i_rst_n) begin
      mQ.delete();
      mActive = 0; mEofPend = 0; mOverflow = 0;
      mKpCount = 0; mDropCount = 0;
    end else begin
      full    = (mQ.size() == DEPTH);
      flagOk  = mActive && i_flag && !i_start;
      eofSlot = mEofPend && !full;
      req     = mActive && (i_start || i_end);
      pushed  = 0;
      if (mQ.size() > 0 && i_kp_ready) void'(mQ.pop_front());
      if (eofSlot) begin
        e = '0; e.eof = 1'b1;
        mQ.push_back(e);
      end else if (flagOk && !full && mKpCount < MAX_KP) begin
        e.eof = 1'b0; e.x = i_coordinate_X; e.y = i_coordinate_Y;
        e.orientation = i_orientation; e.score = i_score;
        mQ.push_back(e);
        pushed = 1;
      end
      if (i_start) begin
        mKpCount = 0; mDropCount = 0; mOverflow = 0;
      end else begin
        if (pushed) mKpCount++;
        if (flagOk && !pushed) begin
          mOverflow = 1;
          if (mDropCount < 65535) mDropCount++;
        end
      end
      mEofPend = (mEofPend && !eofSlot) || req;
      if (i_start) mActive = 1;
      else if (i_end) mActive = 0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge i_clk) begin
    kp_entry_t h;
    h = (mQ.size() > 0) ? mQ[0] : '0;
    checkOutput("valid", 32'(o_kp_valid), 32'(mQ.size() > 0));
    checkOutput("X", 32'(o_kp_X), 32'(h.x));
    checkOutput("Y", 32'(o_kp_Y), 32'(h.y));
    checkOutput("orientation", 32'(o_kp_orientation), 32'(h.orientation));
    checkOutput("score", 32'(o_kp_score), 32'(h.score));
    checkOutput("eof", 32'(o_kp_eof), 32'(h.eof));
    checkOutput("kp_count", 32'(o_kp_count), 32'(mKpCount));
    checkOutput("drop_count", 32'(o_drop_count), 32'(mDropCount));
    checkOutput("overflow", 32'(o_overflow), 32'(mOverflow));
  end

  // Drives one cycle of inputs, lets the edge happen, returns 2 time units
  // after it so callers can sample settled outputs.
  task automatic applyStimulus(input bit st, input bit en, input bit fl,
                               input bit rdy, input int x, input int y,
                               input int o, input int s);
    i_start        = st;
    i_end          = en;
    i_flag         = fl;
    i_kp_ready     = rdy;
    i_coordinate_X = 10'(x);
    i_coordinate_Y = 10'(y);
    i_orientation  = 10'(o);
    i_score        = 8'(s);
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, rdy, 0, 0, 0, 0);
  endtask

  task automatic flagOnce(input bit rdy, input int x, input int y, input int o, input int s);
    applyStimulus(0, 0, 1, rdy, x, y, o, s);
  endtask

  // Pops with ready high until the FIFO is empty; returns entries popped.
  task automatic drainCount(output int popped);
    popped = 0;
    for (int k = 0; k < 4 * DEPTH && o_kp_valid; k++) begin
      popped++;
      idle(1, 1);
    end
    checkOutput("drain_bound", 32'(o_kp_valid), 32'(0));
  endtask

  initial begin
    int cnt;
    int pReady, pFlag, len;
    bit rdy, fl, st;

    $display("[TB] keypoint_fifo bench: DEPTH=%0d MAX_KP=%0d", DEPTH, MAX_KP);

    // Reset state.
    repeat (3) @(posedge i_clk);
    #2;
    checkOutput("reset_valid", 32'(o_kp_valid), 32'(0));
    checkOutput("reset_count", 32'(o_kp_count), 32'(0));
    checkOutput("reset_drop", 32'(o_drop_count), 32'(0));
    checkOutput("reset_overflow", 32'(o_overflow), 32'(0));
    i_rst_n = 1'b1;
    idle(2, 1);

    // Three keypoints streamed through with the consumer always ready.
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    flagOnce(1, 100, 40, 7, 8'h55);
    checkOutput("single_valid", 32'(o_kp_valid), 32'(1));
    checkOutput("single_X", 32'(o_kp_X), 32'(100));
    checkOutput("single_Y", 32'(o_kp_Y), 32'(40));
    checkOutput("single_score", 32'(o_kp_score), 32'h55);
    flagOnce(1, 101, 41, 8, 8'h56);
    flagOnce(1, 102, 42, 9, 8'h57);
    checkOutput("single_third_X", 32'(o_kp_X), 32'(102));
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("single_gap_valid", 32'(o_kp_valid), 32'(0));
    idle(1, 1);
    checkOutput("single_eof", 32'(o_kp_eof), 32'(1));
    checkOutput("single_eof_X", 32'(o_kp_X), 32'(0));
    checkOutput("single_count", 32'(o_kp_count), 32'(3));
    checkOutput("single_drop", 32'(o_drop_count), 32'(0));
    idle(1, 1);
    checkOutput("single_empty", 32'(o_kp_valid), 32'(0));

    // Backpressure: 70 flags into a stalled 64-entry FIFO.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) flagOnce(0, i, i + 1, i + 2, i + 3);
    checkOutput("bp_count", 32'(o_kp_count), 32'(64));
    checkOutput("bp_drop", 32'(o_drop_count), 32'(6));
    checkOutput("bp_overflow", 32'(o_overflow), 32'(1));
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3, 0);
    checkOutput("bp_eof_held", 32'(o_kp_eof), 32'(0));
    checkOutput("bp_head_X", 32'(o_kp_X), 32'(0));
    cnt = 0;
    for (int k = 0; k < 200 && o_kp_valid && !o_kp_eof; k++) begin
      cnt++;
      idle(1, 1);
    end
    checkOutput("bp_eof_position", 32'(cnt), 32'(64));
    checkOutput("bp_eof_seen", 32'(o_kp_eof), 32'(1));
    idle(1, 1);
    checkOutput("bp_drained", 32'(o_kp_valid), 32'(0));

    // Per-frame cap.
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < MAX_KP + 3; i++) flagOnce(1, i, 2 * i, 3, 4);
    checkOutput("cap_count", 32'(o_kp_count), 32'(MAX_KP));
    checkOutput("cap_drop", 32'(o_drop_count), 32'(3));
    checkOutput("cap_overflow", 32'(o_overflow), 32'(1));
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    idle(3, 1);

    // Flag coinciding with i_end: keypoint first, EOF after it.
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    flagOnce(1, 5, 5, 5, 5);
    applyStimulus(0, 1, 1, 1, 6, 6, 6, 6);
    checkOutput("flag_end_X", 32'(o_kp_X), 32'(6));
    checkOutput("flag_end_not_eof", 32'(o_kp_eof), 32'(0));
    idle(1, 1);
    checkOutput("flag_end_eof", 32'(o_kp_eof), 32'(1));
    idle(2, 1);

    // Restart mid-frame: old EOF takes the slot and the new-frame flag drops.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    flagOnce(0, 10, 1, 1, 1);
    flagOnce(0, 11, 1, 1, 1);
    flagOnce(0, 12, 1, 1, 1);
    applyStimulus(1, 0, 1, 0, 99, 1, 1, 1);
    checkOutput("restart_count_clr", 32'(o_kp_count), 32'(0));
    flagOnce(0, 20, 2, 2, 2);
    checkOutput("restart_drop", 32'(o_drop_count), 32'(1));
    checkOutput("restart_overflow", 32'(o_overflow), 32'(1));
    flagOnce(0, 21, 2, 2, 2);
    checkOutput("restart_count", 32'(o_kp_count), 32'(1));
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    drainCount(cnt);
    checkOutput("restart_entries", 32'(cnt), 32'(6));

    // Full FIFO with a pop and a flag on the same edge.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) flagOnce(0, i, 0, 0, 0);
    checkOutput("full_drop0", 32'(o_drop_count), 32'(0));
    flagOnce(1, 200, 0, 0, 0);
    checkOutput("full_drop1", 32'(o_drop_count), 32'(1));
    drainCount(cnt);
    checkOutput("full_occupancy", 32'(cnt), 32'(DEPTH - 1));
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    idle(3, 1);

    // Reset in the middle of a frame with ten keypoints buffered.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) flagOnce(0, 300 + i, 7, 7, 7);
    #1 i_rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(o_kp_valid), 32'(0));
    checkOutput("rst_X", 32'(o_kp_X), 32'(0));
    checkOutput("rst_count", 32'(o_kp_count), 32'(0));
    checkOutput("rst_overflow", 32'(o_overflow), 32'(0));
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1, 1);
      checkOutput("rst_no_eof", 32'(o_kp_valid), 32'(0));
    end

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      pReady = $urandom_range(0, 100);
      pFlag  = $urandom_range(10, 100);
      len    = $urandom_range(20, 220);
      applyStimulus(1, 0, 0, $urandom_range(0, 99) < pReady, 0, 0, 0, 0);
      for (int c = 0; c < len; c++) begin
        rdy = ($urandom_range(0, 99) < pReady);
        fl  = ($urandom_range(0, 99) < pFlag);
        st  = ($urandom_range(0, 199) == 0);
        applyStimulus(st, 0, fl, rdy, $urandom_range(0, 639),
                      $urandom_range(0, 479), $urandom_range(0, 1023),
                      $urandom_range(0, 255));
      end
      if ($urandom_range(0, 4) != 0)
        applyStimulus(0, 1, $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 639), $urandom_range(0, 479), 1, 2);
      for (int g = 0; g < int'($urandom_range(0, 6)); g++)
        applyStimulus(0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                      1, 2, 3, 4);
    end
    idle(2 * DEPTH + 10, 1);
    checkOutput("final_empty", 32'(o_kp_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/keypoint_fifo.md
# keypoint_fifo

Buffers keypoints from the FAST detector stream and hands them to the descriptor/matching stage over a valid/ready handshake. Accepts one keypoint per cycle on `i_flag` and caps keypoints per frame at `MAX_KP`. Closes every frame with an end-of-frame (EOF) token that is never dropped. Sits directly downstream of `FAST_Detector` (640x480, one pixel per cycle) and absorbs backpressure the detector cannot honour.

## Interface
- `DEPTH`, 64: FIFO entries; power of two, at least 4.
- `MAX_KP`, 500: max keypoints accepted per frame; 1..1023.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_coordinate_X` in 10: keypoint column.
- `i_coordinate_Y` in 10: keypoint row.
- `i_orientation` in 10: keypoint orientation.
- `i_score` in 8: keypoint score.
- `i_flag` in 1: keypoint valid this cycle.
- `i_start` in 1: one-cycle pulse, first pixel of a frame.
- `i_end` in 1: one-cycle pulse, last pixel of a frame.
- `o_kp_valid` out 1: head entry valid.
- `i_kp_ready` in 1: consumer accepts the head entry.
- `o_kp_X` out 10, `o_kp_Y` out 10, `o_kp_orientation` out 10, `o_kp_score` out 8: head keypoint fields; all zero on an EOF token.
- `o_kp_eof` out 1: head entry is the EOF token.
- `o_kp_count` out 10: keypoints accepted in the current frame.
- `o_drop_count` out 16: keypoints dropped in the current frame; saturates at 0xFFFF.
- `o_overflow` out 1: sticky; at least one drop since the last `i_start`.

## Operation
- States:
  - IDLE (reset): inputs are ignored except `i_start`.
  - ACTIVE: frame in progress.
- IDLE + `i_start` -> ACTIVE. On that edge, clear `o_kp_count`, `o_drop_count` and `o_overflow`.
- ACTIVE + `i_end` -> IDLE, and set `eof_pend`.
- ACTIVE + `i_start` (frame restarted with no `i_end`): stay ACTIVE, set `eof_pend` for the old frame, clear the counters.
- `i_flag` is ignored in any cycle where `i_start` is high, and ignored in IDLE.
- At most one write per cycle. Priority:
  1. `eof_pend` with FIFO not full: write the EOF token and clear `eof_pend`.
  2. Accepted `i_flag`: write the keypoint.
- A keypoint is dropped (drop count +1, `o_overflow` set) if any of these hold:
  - FIFO is full;
  - `o_kp_count == MAX_KP`;
  - the EOF token takes the write slot that cycle.
- An accepted keypoint increments `o_kp_count`.
- `i_flag` together with `i_end` in the same cycle: the keypoint is handled normally, `eof_pend` is set on that edge, and the EOF token is written on a later cycle.
- `eof_pend` holds until space is available. A second EOF request while one is pending is merged; tokens are never duplicated.
- Pop happens when `o_kp_valid && i_kp_ready`. `i_kp_ready` is ignored when the FIFO is empty.
- Full/empty are judged on occupancy before the edge. A write when full is refused even if a pop happens in the same cycle. Push and pop in the same cycle are allowed otherwise.
- Pointers are `log2(DEPTH)+1` bits and wrap naturally. Full is MSBs differ with the rest equal; empty is pointers equal.

## Timing
- Reset values: every output 0; state IDLE; pointers 0; `eof_pend` 0.
- Output fields are read from the head entry (show-ahead): stable while `o_kp_valid` is high and no pop occurs.
- Latency: a keypoint written at edge N into an empty FIFO has `o_kp_valid=1` in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 push and 1 pop per cycle.
- `o_kp_count` and `o_drop_count` update on the same edge as the write or drop decision.
- Reset asserted mid-frame: the FIFO is flushed and no EOF token is emitted for the interrupted frame.

## Structure
- Shared package/header: `COORD_W=10`, `ORIENT_W=10`, `SCORE_W=8`, and the entry packing `{eof, X, Y, orientation, score}` = 39 bits. The descriptor stage reuses this packing.
- One sub-module, `sync_fifo`: parameterised width and depth, registered memory, full/empty flags.
- Frame control, priority and counters live in the top level.

## Test plan
- Single keypoint: `i_start`, then 3 flags at (100,40,s=0x55) … with `i_kp_ready=1`, then `i_end` → 3 entries in order, each valid 1 cycle after its write, then EOF; `o_kp_count=3`, `o_drop_count=0`.
- Backpressure: `DEPTH=64`, `i_kp_ready=0`, 70 consecutive flags → 64 stored, `o_drop_count=6`, `o_overflow=1`. `i_end` is then held pending; after one pop, EOF is written as entry 64.
- Cap: `MAX_KP=5`, 8 flags → `o_kp_count=5`, `o_drop_count=3`; 5 keypoints then EOF.
- Simultaneous events: flag with `i_end` → keypoint then EOF. `i_start` mid-frame → old frame's EOF precedes any new-frame keypoint, and the flag coinciding with the EOF write is dropped and counted in the new frame.
- Full push+pop: FIFO full, `i_kp_ready=1`, flag same cycle → flag dropped, occupancy 63.
- Reset mid-frame: 10 keypoints buffered, assert `i_rst_n=0` → `o_kp_valid=0`, all outputs 0, no EOF emitted after release.
